// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute stage and the sequential divider.
// The stage drives the request side; the divider drives status and result.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, control, A, B,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, control, A, B,
        output busy, done, result, zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per clock; B==0 and signed overflow finish at acceptance.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [4:0] OP_DIV  = 5'b01110;
    localparam logic [4:0] OP_DIVU = 5'b01111;
    localparam logic [4:0] OP_REM  = 5'b10000;
    localparam logic [4:0] OP_REMU = 5'b10001;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;
    logic             q_neg;
    logic             r_neg;
    logic             is_rem;

    logic             op_ok;
    logic             op_sgn;
    logic             op_rem;
    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] spec_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             last;

    always_comb begin
        op_ok  = 1'b0;
        op_sgn = 1'b0;
        op_rem = 1'b0;
        unique case (1'b1)
            (bus.control == OP_DIV):  begin op_ok = 1'b1; op_sgn = 1'b1; end
            (bus.control == OP_DIVU): begin op_ok = 1'b1; end
            (bus.control == OP_REM):  begin op_ok = 1'b1; op_sgn = 1'b1; op_rem = 1'b1; end
            (bus.control == OP_REMU): begin op_ok = 1'b1; op_rem = 1'b1; end
            default: ;
        endcase
    end

    assign accept   = bus.start && op_ok && (state != CALC);
    assign a_neg    = op_sgn && bus.A[WIDTH-1];
    assign b_neg    = op_sgn && bus.B[WIDTH-1];
    assign a_mag    = a_neg ? -bus.A : bus.A;
    assign b_mag    = b_neg ? -bus.B : bus.B;
    assign div_zero = (bus.B == '0);
    assign ovf      = op_sgn && (bus.A == MIN_NEG) && (bus.B == '1);

    always_comb begin
        if (div_zero)
            spec_res = op_rem ? bus.A : '1;
        else
            spec_res = op_rem ? '0 : bus.A;
    end

    // Shift the next dividend bit in; keep the trial difference if it is non-negative.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign fits    = !diff[WIDTH];
    assign rem_nx  = fits ? diff : shifted;
    assign quo_nx  = {quo[WIDTH-2:0], fits};
    assign q_fin   = q_neg ? -quo_nx : quo_nx;
    assign r_fin   = r_neg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    assign last    = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            count    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            is_rem   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept && (div_zero || ovf)) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= spec_res;
                    end else if (accept) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        rem    <= '0;
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        count  <= '0;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        is_rem <= op_rem;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
                CALC: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= is_rem ? r_fin : q_fin;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = (result_q == '0);
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed plan cases plus
// randomized operations against an arithmetic reference model.
module tb_seq_divider;
    localparam int W = 32;
    localparam logic [4:0] C_DIV  = 5'b01110;
    localparam logic [4:0] C_DIVU = 5'b01111;
    localparam logic [4:0] C_REM  = 5'b10000;
    localparam logic [4:0] C_REMU = 5'b10001;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] last_exp = '0;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [4:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] sr;
        sa = a;
        sb = b;
        if (b == '0)
            return (op == C_DIV || op == C_DIVU) ? '1 : a;
        if ((op == C_DIV || op == C_REM) && a == MINV && b == '1)
            return (op == C_DIV) ? a : '0;
        case (op)
            C_DIV:   begin sr = sa / sb; return sr; end
            C_REM:   begin sr = sa % sb; return sr; end
            C_DIVU:  return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        if (b == '0) return 1;
        if ((op == C_DIV || op == C_REM) && a == MINV && b == '1) return 1;
        return W + 1;
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] res,
                          output int cyc, output int bcyc);
        bus.start   = 1'b1;
        bus.control = op;
        bus.A       = a;
        bus.B       = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.A       = $urandom;
        bus.B       = $urandom;
        bus.control = 5'($urandom_range(0, 31));
        cyc  = 1;
        bcyc = 0;
        while (!bus.done && cyc < 60) begin
            if (bus.busy) bcyc++;
            @(negedge clk);
            cyc++;
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.result !== '0 || bus.zero !== 1'b1) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b result=%h zero=%b want 0 0 0 1",
                     bus.busy, bus.done, bus.result, bus.zero);
        end
    endtask

    task automatic test_directed();
        logic [4:0]   ops [9];
        logic [W-1:0] as  [9];
        logic [W-1:0] bs  [9];
        logic [W-1:0] ex  [9];
        logic [W-1:0] res;
        int cyc, bcyc, lat;
        ops = '{C_DIVU, C_REMU, C_DIV, C_REM, C_REM, C_DIVU, C_REM, C_DIV, C_REM};
        as  = '{100, 100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 100, 5, 5, MINV, MINV};
        bs  = '{7, 7, 7, 7, 32'hFFFF_FFF9, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ex  = '{14, 2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 2, 32'hFFFF_FFFF, 5, MINV, 0};
        for (int i = 0; i < 9; i++) begin
            lat = (bs[i] == 0 || (as[i] == MINV && bs[i] == '1)) ? 1 : W + 1;
            run_op(ops[i], as[i], bs[i], res, cyc, bcyc);
            checks++;
            if (res !== ex[i] || cyc != lat || bcyc != lat - 1 ||
                bus.zero !== (ex[i] == 0)) begin
                failures++;
                $display("FAIL directed%0d: result=%h lat=%0d busy=%0d zero=%b want %h %0d %0d %b",
                         i, res, cyc, bcyc, bus.zero, ex[i], lat, lat - 1, ex[i] == 0);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.result !== ex[i]) begin
                failures++;
                $display("FAIL directed%0d_hold: done=%b result=%h want 0 %h",
                         i, bus.done, bus.result, ex[i]);
            end
            last_exp = ex[i];
        end
    endtask

    task automatic test_random();
        logic [4:0] opset [4];
        logic [4:0] op;
        logic [W-1:0] a, b, res, ex;
        int cyc, bcyc, lat;
        opset = '{C_DIV, C_DIVU, C_REM, C_REMU};
        for (int i = 0; i < 40; i++) begin
            op = opset[$urandom_range(0, 3)];
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       begin a = MINV; b = '1; end
                2, 3:    b = W'($urandom_range(1, 20));
                4:       b = -W'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ex  = model(op, a, b);
            lat = exp_lat(op, a, b);
            run_op(op, a, b, res, cyc, bcyc);
            checks++;
            if (res !== ex || cyc != lat || bus.zero !== (ex == 0)) begin
                failures++;
                $display("FAIL random%0d op=%b a=%h b=%h: result=%h lat=%0d want %h %0d",
                         i, op, a, b, res, cyc, ex, lat);
            end
            last_exp = ex;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2;
        int c1, b1, c2, b2;
        run_op(C_DIVU, 100, 7, r1, c1, b1);
        run_op(C_DIVU, 9, 3, r2, c2, b2);
        checks++;
        if (r1 !== 14 || r2 !== 3 || c2 != W + 1 || b2 != W) begin
            failures++;
            $display("FAIL back_to_back: r1=%0d r2=%0d lat2=%0d busy2=%0d want 14 3 %0d %0d",
                     r1, r2, c2, b2, W + 1, W);
        end
        last_exp = 3;
        @(negedge clk);
    endtask

    task automatic test_ignore_mid();
        int cyc;
        int extra;
        bus.start = 1'b1; bus.control = C_DIVU; bus.A = 1000; bus.B = 10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.control = C_DIVU; bus.A = 7; bus.B = 7;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.result !== last_exp || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_calc_result: result=%h busy=%b want %h 1",
                     bus.result, bus.busy, last_exp);
        end
        cyc = 7;
        while (!bus.done && cyc < 60) begin @(negedge clk); cyc++; end
        checks++;
        if (bus.result !== 100 || cyc != W + 1) begin
            failures++;
            $display("FAIL ignore_mid: result=%0d lat=%0d want 100 %0d",
                     bus.result, cyc, W + 1);
        end
        extra = 0;
        repeat (40) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
        checks++;
        if (extra != 0 || bus.result !== 100) begin
            failures++;
            $display("FAIL ignore_mid_after: activity=%0d result=%0d want 0 100",
                     extra, bus.result);
        end
        last_exp = 100;
    endtask

    task automatic test_bad_op();
        int act = 0;
        bus.start = 1'b1; bus.control = 5'b00000; bus.A = 50; bus.B = 5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) begin if (bus.done || bus.busy) act++; @(negedge clk); end
        checks++;
        if (act != 0 || bus.result !== last_exp) begin
            failures++;
            $display("FAIL bad_op: activity=%0d result=%h want 0 %h",
                     act, bus.result, last_exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int cyc, bcyc, act;
        bus.start = 1'b1; bus.control = C_DIVU; bus.A = 1000; bus.B = 10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.result !== '0 || bus.zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (40) begin @(negedge clk); if (bus.done || bus.busy) act++; end
        checks++;
        if (act != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: activity=%0d want 0", act);
        end
        run_op(C_DIVU, 1000, 10, res, cyc, bcyc);
        checks++;
        if (res !== 100 || cyc != W + 1) begin
            failures++;
            $display("FAIL reset_recover: result=%0d lat=%0d want 100 %0d",
                     res, cyc, W + 1);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.control = '0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_mid();
        test_bad_op();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
